tmds_encoder: RTL and testbench
===============================

// Module: tmds_encoder
// PURPOSE
//  DVI/HDMI TMDS 8b/10b encoder for one colour channel: 8-bit pixel byte -> 10-bit DC-balanced symbol.
//  Outputs one of four control symbols during blanking.
//  Three instances (R, G, B) sit between the palette RAM and the 10:1 serializer on the 25 MHz pixel clock.
//  Blue carries {vsync, hsync} on CD; red and green tie CD to 2'b00.
// PARAMETERS
//  None. All widths are fixed by the DVI 1.0 TMDS algorithm.
// PORTS
//  clk    in   1   pixel clock; all state on rising edge
//  rst_n  in   1   synchronous, active-low reset
//  VD     in   8   video data byte (palette output)
//  CD     in   2   control bits {C1,C0}, used when VDE=0
//  VDE    in   1   1 = active video (encode VD), 0 = blanking (emit control symbol)
//  TMDS   out  10  encoded symbol; bit 0 is serialized first
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (clk, rst_n).
//  - Latency: exactly 1 cycle. TMDS is registered from VD/CD/VDE sampled on the same edge.
//  - Reset (rst_n=0 at edge): TMDS <= 10'b1101010100 (CD=00 control code); disparity cnt <= 0.
//  - Stage 1, transition minimise:
//    - N1d = popcount(VD).
//    - useXnor = (N1d>4) | (N1d==4 & VD[0]==0).
//    - q_m[0] = VD[0].
//    - q_m[i] = useXnor ? ~(q_m[i-1]^VD[i]) : (q_m[i-1]^VD[i]) for i=1..7.
//    - q_m[8] = ~useXnor.
//  - Stage 2, DC balance: N1/N0 = count of ones/zeros in q_m[7:0]. cnt is a 5-bit signed running disparity.
//    - Case A, cnt==0 | N1==N0:
//      - TMDS = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
//      - cnt += q_m[8] ? (N1-N0) : (N0-N1).
//    - Case B, (cnt>0 & N1>N0) | (cnt<0 & N0>N1):
//      - TMDS = {1, q_m[8], ~q_m[7:0]}.
//      - cnt += 2*q_m[8] + (N0-N1).
//    - Case C, else:
//      - TMDS = {0, q_m[8], q_m[7:0]}.
//      - cnt += (N1-N0) - 2*(~q_m[8]).
//  - VDE=0: TMDS <= control code by CD. cnt <= 0.
//    - 00 -> 10'b1101010100
//    - 01 -> 10'b0010101011
//    - 10 -> 10'b0101010100
//    - 11 -> 10'b1010101011
//  - VDE 0->1: the first data symbol uses cnt=0 (Case A).
//  - No back-pressure or handshake; a new symbol is produced every cycle.
//  - Arithmetic: compute with signed widths sized to prevent overflow.
//    - cnt never exceeds +/-10 for legal input, so 5-bit signed suffices.
//    - Counts are 4-bit unsigned; sign-extend before mixing with cnt.
//  - Reset mid-line behaves like VDE=0 with CD=00, and also clears cnt.
//  - X/undefined CD while VDE=1 must not affect TMDS.
// STRUCTURE
//  - Shared package (tmds_pkg):
//    - CTRL_00/01/10/11 10-bit control-code constants.
//    - signed typedef disp_t (5-bit) for the disparity counter.
//    - popcount8 function.
//  - Single flat module:
//    - combinational q_m and popcount logic;
//    - one always_ff for TMDS and cnt.
//  - No sub-module needed; popcount8 may be a package function.
// TESTING
//  1. Reset, then VDE=0, CD=00 -> TMDS=10'b1101010100; cnt=0. Repeat for CD=01/10/11 with the codes above.
//  2. VDE=1, VD=8'h00 three cycles from cnt=0 -> symbols 10'h100, 10'h3FF, 10'h100; cnt -8, +2, -6.
//  3. From cnt=0, VD=8'hFF -> TMDS=10'h200, cnt=-8.
//     Then VDE=0 for 1 cycle and VD=8'hFF again -> 10'h200 (cnt was cleared).
//  4. Random VD/VDE stream vs. a behavioural DVI reference model, 1-cycle aligned:
//     - all symbols match;
//     - every decoded data symbol returns VD;
//     - |cnt| <= 10 always.
//  5. Long VDE=1 run (>=640 cycles, random VD) -> cumulative ones-minus-zeros of all output symbols stays bounded (|x|<=10).
//  6. Assert rst_n=0 mid-run with VDE=1 -> next TMDS=10'b1101010100.
//     After release, the first data symbol follows Case A.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-period symbols, the disparity type and a byte popcount.
package tmds_pkg;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef logic signed [4:0] disp_t;

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(d[i]);
    return c;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// One TMDS colour channel: 8b/10b transition-minimised, DC-balanced symbol per pixel clock,
// or a fixed control symbol during blanking. One cycle of latency.
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] VD,
  input  logic [1:0] CD,
  input  logic       VDE,
  output logic [9:0] TMDS
);

  logic [3:0]        n1d, n1, n0;
  logic              use_xnor;
  logic [8:0]        q_m;
  logic signed [6:0] cnt_x, diff, q8x2, nq8x2, acc;
  logic [9:0]        tmds_d, tmds_q;
  disp_t             cnt_d, cnt_q;

  // Stage 1: pick XOR or XNOR chaining to minimise transitions.
  always_comb begin
    logic [8:0] qm;
    n1d      = popcount8(VD);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !VD[0]);
    qm       = '0;
    qm[0]    = VD[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ VD[i]) : (qm[i-1] ^ VD[i]);
    qm[8]    = ~use_xnor;
    q_m      = qm;
  end

  // Stage 2: DC balance. Arithmetic runs 7 bits wide so intermediates never wrap.
  always_comb begin
    n1     = popcount8(q_m[7:0]);
    n0     = 4'd8 - n1;
    cnt_x  = {{2{cnt_q[4]}}, cnt_q};
    diff   = signed'({3'b000, n1}) - signed'({3'b000, n0});
    q8x2   = q_m[8] ? 7'sd2 : 7'sd0;
    nq8x2  = q_m[8] ? 7'sd0 : 7'sd2;
    tmds_d = '0;
    acc    = '0;
    if (!VDE) begin
      unique case (CD)
        2'b00: tmds_d = CTRL_00;
        2'b01: tmds_d = CTRL_01;
        2'b10: tmds_d = CTRL_10;
        2'b11: tmds_d = CTRL_11;
      endcase
    end else if ((cnt_q == 5'sd0) || (n1 == n0)) begin
      tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      acc    = q_m[8] ? (cnt_x + diff) : (cnt_x - diff);
    end else if ((!cnt_q[4] && (n1 > n0)) || (cnt_q[4] && (n0 > n1))) begin
      tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
      acc    = cnt_x + q8x2 - diff;
    end else begin
      tmds_d = {1'b0, q_m[8], q_m[7:0]};
      acc    = cnt_x + diff - nq8x2;
    end
    cnt_d = disp_t'(acc[4:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmds_q <= CTRL_00;
      cnt_q  <= '0;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign TMDS = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Randomised scoreboard bench for tmds_encoder against a symbol-disparity reference model.
module tb_tmds_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] VD = '0;
  logic [1:0] CD = '0;
  logic       VDE = 1'b0;
  logic [9:0] TMDS;

  tmds_encoder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .VD   (VD),
    .CD   (CD),
    .VDE  (VDE),
    .TMDS (TMDS)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic [9:0] sym;
    logic       data;
    logic [7:0] vd;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         m_cnt = 0;
  int         disp = 0;
  logic [9:0] ctrl_tab [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: build q_m, then invert the payload whenever that moves the
  // running disparity toward zero; disparity is tracked as the symbol's own ones-minus-zeros.
  function automatic logic [9:0] ref_enc(input logic r, input logic vde,
                                         input logic [7:0] vd, input logic [1:0] cd);
    logic [8:0] qm;
    logic [9:0] sym;
    logic       xn, inv;
    int         ones, n1, n0;
    if (!r || !vde) begin
      m_cnt = 0;
      return r ? ctrl_tab[cd] : ctrl_tab[0];
    end
    ones  = $countones(vd);
    xn    = (ones > 4) || (ones == 4 && !vd[0]);
    qm[0] = vd[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ vd[i]) : (qm[i-1] ^ vd[i]);
    qm[8] = !xn;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (m_cnt == 0 || n1 == n0) inv = !qm[8];
    else inv = (m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1);
    sym   = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    m_cnt = m_cnt + 2 * $countones(sym) - 10;
    return sym;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic step(input logic r, input logic vde, input logic [7:0] vd,
                      input logic [1:0] cd, input logic use_k, input logic [9:0] k);
    exp_t       e;
    logic [9:0] m;
    @(posedge clk);
    #3;
    rst_n = r; VDE = vde; VD = vd; CD = cd;
    m      = ref_enc(r, vde, vd, cd);
    e.sym  = use_k ? k : m;
    e.data = r && vde;
    e.vd   = vd;
    sb.push_back(e);
  endtask

  // Monitor: a symbol appears one edge after its inputs were applied.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tmds", 32'(TMDS), 32'(e.sym));
        if (e.data) begin
          check("decode", 32'(decode(TMDS)), 32'(e.vd));
          disp = disp + 2 * $countones(TMDS) - 10;
          check("disp_bound", 32'(disp <= 10 && disp >= -10), 32'd1);
        end else begin
          disp = 0;
        end
      end
    end
  end

  initial begin
    ctrl_tab[0] = 10'b1101010100;
    ctrl_tab[1] = 10'b0010101011;
    ctrl_tab[2] = 10'b0101010100;
    ctrl_tab[3] = 10'b1010101011;

    step(1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100);
    step(1'b0, 1'b1, 8'h5A, 2'b11, 1'b1, 10'b1101010100);
    for (int c = 0; c < 4; c++)
      step(1'b1, 1'b0, 8'($urandom), 2'(c), 1'b1, ctrl_tab[c]);

    // Zero bytes from a balanced start walk disparity -8, +2, -6.
    step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100);
    step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF);
    step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h100);

    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100);
    step(1'b1, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h200);
    step(1'b1, 1'b0, 8'hFF, 2'b00, 1'b1, 10'b1101010100);
    step(1'b1, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h200);

    for (int n = 0; n < 1500; n++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
           8'($urandom), 2'($urandom), 1'b0, 10'h000);

    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 10'h000);
    for (int n = 0; n < 700; n++)
      step(1'b1, 1'b1, 8'($urandom), 2'($urandom), 1'b0, 10'h000);

    // Reset during active video, then the first byte sees a balanced start.
    step(1'b0, 1'b1, 8'($urandom), 2'b11, 1'b1, 10'b1101010100);
    step(1'b1, 1'b1, 8'hFF, 2'b00, 1'b1, 10'h200);
    step(1'b1, 1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF);

    @(posedge clk);
    #3;
    VDE = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
